// File: rtl/spi_master_param_pkg.sv
// spi_pkg: shared types and helpers for the parametrised SPI master.
//   spi_state_t - frame sequencer states (IDLE, LEAD, SHIFT, TRAIL)
//   spi_mode_t  - per-frame clock mode {cpol, cpha}
//   calc_ss_w() - width of the slave-select index for a given select count
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic int calc_ss_w(input int num_ss);
        return (num_ss > 1) ? $clog2(num_ss) : 1;
    endfunction

endpackage

// File: rtl/spi_master_param_clk_gen.sv
// spi_clk_gen: half-period timer for the SPI master.
// A down-counter reloaded with CLK_DIV-1; edge_stb pulses for one cycle each
// time it reaches zero while enabled, i.e. every CLK_DIV cycles.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   en       - run the timer; when low the counter is held at its reload value
//   edge_stb - one-cycle strobe marking the end of a half-period
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic edge_stb
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= CW'(CLK_DIV - 1);
        end else if (!en || cnt == '0) begin
            cnt <= CW'(CLK_DIV - 1);
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    assign edge_stb = en && (cnt == '0);

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master, all four CPOL/CPHA
// modes selected per frame, NUM_SS active-low selects.
// Optional build macro: SPI_LSB_FIRST_EN adds input lsb_first (latched at
// accept) for LSB-first frames; without it frames are always MSB-first.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   tx_valid/tx_ready         - frame request handshake
//   tx_data, tx_ss_sel        - word to send and index of the select to drive
//   cpol, cpha                - clock mode for the frame
//   rx_valid, rx_data         - received word, rx_valid pulses one cycle
//   busy                      - frame in progress
//   sclk, mosi, miso, ss_n    - SPI pins
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request, sclk follows cpol
// LEAD  | select asserted, sclk at idle level for one half-period
// SHIFT | 2*DATA_W sclk half-periods, shifting out mosi / sampling miso
// TRAIL | select still asserted, sclk at idle level for one half-period
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_SS  = 1,
    localparam int SS_W   = calc_ss_w(NUM_SS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SS_W-1:0]   tx_ss_sel,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int EW = $clog2(2 * DATA_W + 1);

    spi_state_t        state;
    spi_mode_t         mode_q;
    logic [DATA_W-1:0] shreg;
    logic [SS_W-1:0]   sel_q;
    logic [EW-1:0]     edges_left;
    logic              start_q;
    logic              lsb_q;
    logic              gen_en;
    logic              edge_stb;
    logic              do_edge;
    logic              tx_bit;
    logic [DATA_W-1:0] shift_in;
    logic [NUM_SS-1:0] sel_mask;

    // start_q holds the timer off for the accept cycle so the select, and
    // everything timed from it, starts one cycle after the handshake. This is
    // what gives back-to-back frames a two-cycle deselect gap.
    assign gen_en = (state != IDLE) && !start_q;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (gen_en),
        .edge_stb (edge_stb)
    );

`ifndef SPI_LSB_FIRST_EN
    assign lsb_q = 1'b0;
`endif

    assign tx_bit   = lsb_q ? shreg[0] : shreg[DATA_W-1];
    assign shift_in = lsb_q ? {miso, shreg[DATA_W-1:1]} : {shreg[DATA_W-2:0], miso};

    // An out-of-range index matches nothing, so the frame runs deselected.
    always_comb begin
        sel_mask = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (sel_q == SS_W'(i)) sel_mask[i] = 1'b0;
        end
    end

    // The LEAD->SHIFT strobe is sclk edge 1; SHIFT strobes are edges 2..2N and
    // the strobe seen with edges_left == 0 closes the last half-period.
    assign do_edge = edge_stb && ((state == LEAD) ||
                                  (state == SHIFT && edges_left != '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= '0;
            shreg      <= '0;
            sel_q      <= '0;
            edges_left <= '0;
            start_q    <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            ss_n       <= '1;
`ifdef SPI_LSB_FIRST_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            start_q  <= 1'b0;

            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (tx_valid && tx_ready) begin
                        shreg      <= tx_data;
                        sel_q      <= tx_ss_sel;
                        mode_q     <= '{cpol: cpol, cpha: cpha};
                        edges_left <= EW'(2 * DATA_W);
                        start_q    <= 1'b1;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= LEAD;
`ifdef SPI_LSB_FIRST_EN
                        lsb_q      <= lsb_first;
`endif
                    end
                end
                LEAD: begin
                    if (start_q) begin
                        ss_n <= sel_mask;
                        if (!mode_q.cpha) mosi <= tx_bit;
                    end
                    if (edge_stb) state <= SHIFT;
                end
                SHIFT: begin
                    if (edge_stb && edges_left == '0) begin
                        sclk  <= mode_q.cpol;
                        state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (edge_stb) begin
                        ss_n     <= '1;
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (do_edge) begin
                sclk       <= ~sclk;
                edges_left <= edges_left - EW'(1);
                // edges_left even before the decrement means an odd edge.
                if (!edges_left[0]) begin
                    if (mode_q.cpha) mosi  <= tx_bit;
                    else             shreg <= shift_in;
                end else begin
                    if (mode_q.cpha)                  shreg <= shift_in;
                    else if (edges_left != EW'(1))    mosi  <= tx_bit;
                end
            end
        end
    end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised, full-duplex SPI master that replaces the fixed-width, transmit-only `fsm_spi`. It accepts words over a valid/ready handshake and drives `sclk`, `mosi` and one of `NUM_SS` active-low selects. It samples `miso` into a receive word and supports all four CPOL/CPHA modes, selected per frame. It sits between the system-side command logic and the board SPI pins.

## Interface
- `DATA_W`, 8: bits per frame, 2..32.
- `CLK_DIV`, 4: `clk` cycles per `sclk` half-period, ≥1.
- `NUM_SS`, 1: number of slave selects, 1..8. `SS_W = (NUM_SS>1) ? $clog2(NUM_SS) : 1`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: frame request.
- `tx_ready` out 1: block can accept a frame.
- `tx_data` in DATA_W: word to transmit.
- `tx_ss_sel` in SS_W: index of the select to assert.
- `cpol` in 1: clock polarity for the frame.
- `cpha` in 1: clock phase for the frame.
- `rx_valid` out 1: one-cycle pulse when the received word is ready.
- `rx_data` out DATA_W: received word, held until the next `rx_valid`.
- `busy` out 1: frame in progress.
- `sclk` out 1, `mosi` out 1, `miso` in 1.
- `ss_n` out NUM_SS: active-low selects.

## Operation
- Reset values: `tx_ready`=1, `busy`=0, `rx_valid`=0, `rx_data`=0, `sclk`=0, `mosi`=0, `ss_n`=all 1.
- States are IDLE, LEAD, SHIFT and TRAIL.
- **IDLE**
  - `tx_ready`=1.
  - `sclk` equals the registered `cpol`, updated every IDLE cycle.
  - On `tx_valid && tx_ready`, latch `tx_data`, `tx_ss_sel`, `cpol` and `cpha`, then go to LEAD.
- **LEAD** (CLK_DIV cycles)
  - `ss_n[sel]`=0. No other select is ever low.
  - `sclk`=cpol.
  - If cpha=0, `mosi` presents the MSB for the whole of LEAD.
- **SHIFT** (2·DATA_W half-periods)
  - `sclk` toggles at the start of each half-period; edge 1 is the first cycle of SHIFT.
  - cpha=0: sample `miso` on odd edges; shift `mosi` on even edges, except the final edge.
  - cpha=1: shift `mosi` on odd edges (edge 1 presents the MSB); sample on even edges.
  - `miso` is captured into the shift register LSB and shifted left.
- **TRAIL** (CLK_DIV cycles)
  - `sclk`=cpol and `ss_n[sel]`=0.
  - At the end of TRAIL: `ss_n` goes all 1, `rx_data` is updated, `rx_valid` pulses for one cycle, and the state returns to IDLE.
- `busy` = not IDLE; `tx_ready` = IDLE.
- `tx_ss_sel` ≥ NUM_SS: the frame still runs, but no select is asserted.
- Changing `cpol`, `cpha`, `tx_data` or `tx_ss_sel` during a frame has no effect on that frame.
- `rst` asserted mid-frame: all outputs return to their reset values asynchronously, and the frame is discarded with no `rx_valid`.
- `mosi` is held at its last value outside SHIFT, except in LEAD when cpha=0 (MSB presented).

## Timing
- Accept on edge N. `ss_n[sel]` is low from N+1 for exactly (2·DATA_W+2)·CLK_DIV cycles.
- `rx_valid` and `tx_ready` go high on the first cycle `ss_n` is back high.
- Back-to-back frames: a request held high is accepted in that same first IDLE cycle. `ss_n` is high for ≥2 cycles between frames.
- Each frame carries exactly 2·DATA_W `sclk` edges.
- `sclk` half-period is exactly CLK_DIV cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `SPI_LSB_FIRST_EN` defined:
  - Adds input `lsb_first` (1 bit), latched at accept.
  - When it is 1, bit 0 is transmitted first, and received bits enter at the MSB and shift right.
- `SPI_LSB_FIRST_EN` undefined: the port is absent and frames are always MSB-first.

## Structure
- Package `spi_pkg` holds:
  - the `spi_state_t` enum {IDLE, LEAD, SHIFT, TRAIL};
  - the `spi_mode_t` struct {cpol, cpha};
  - the function computing SS_W.
- Sub-module `spi_clk_gen` holds the half-period counter and emits a one-cycle `edge_stb` every CLK_DIV cycles while enabled. It is reused by the top-level FSM for LEAD and TRAIL timing.

## Test plan
- Mode 0, DATA_W=8, CLK_DIV=2, NUM_SS=2, sel=1, `tx_data`=0xA5, `miso` looped from `mosi` → `ss_n`=2'b01 for 36 cycles, 16 `sclk` edges, `rx_valid` pulse, `rx_data`=0xA5.
- Mode 3, `tx_data`=0x3C, `miso` driven with 0xC3 by a slave model → `sclk` idles at 1, `mosi` bits change on falling edges, `rx_data`=0xC3.
- `tx_valid` held high with frames 0x01 then 0x02 → two frames, `ss_n` high for 2 cycles between them, two `rx_valid` pulses in order.
- `rst` asserted at SHIFT edge 5, released 3 cycles later → outputs at reset values immediately, no `rx_valid`, next frame completes normally.
- CLK_DIV=1, DATA_W=16, `tx_data`=0x8001 → `ss_n` low for 34 cycles, `sclk` toggles every cycle, loopback `rx_data`=0x8001.
- With `SPI_LSB_FIRST_EN` defined and `lsb_first`=1, `tx_data`=0x01 → `mosi` high only during the first bit, loopback `rx_data`=0x01.
